// File: rtl/raytrace_pkg.sv
// Shared types and constants for the ray-trace pixel scheduler.
//   sched_state_e : scheduler FSM states
//   color_t       : RGB444 pixel colour
//   depth_t       : unsigned hit distance
//   DefaultBgColor: colour emitted when no sphere is hit
package raytrace_pkg;

  localparam int unsigned PkgColorW = 12;
  localparam int unsigned PkgDepthW = 16;

  typedef logic [PkgColorW-1:0] color_t;
  typedef logic [PkgDepthW-1:0] depth_t;

  localparam color_t DefaultBgColor = 12'h000;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StSphere,
    StWrite
  } sched_state_e;

endpackage

// File: rtl/raytrace_hit_select.sv
// Nearest-hit selector: tracks the closest sphere hit seen for the current pixel.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : start of pixel, reset to "no hit" (depth all-ones, background colour)
//   result      : a counted core result is present this cycle
//   sphere_hit  : the ray hits the sphere under test
//   hit_depth   : hit distance
//   hit_color   : shaded colour of the hit
//   sel_color   : best colour including this cycle's result (next-state view)
module raytrace_hit_select
  import raytrace_pkg::*;
#(
  parameter int unsigned        COLOR_W  = PkgColorW,
  parameter int unsigned        DEPTH_W  = PkgDepthW,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               result,
  input  logic               sphere_hit,
  input  logic [DEPTH_W-1:0] hit_depth,
  input  logic [COLOR_W-1:0] hit_color,
  output logic [COLOR_W-1:0] sel_color
);

  logic [DEPTH_W-1:0] best_depth_q, best_depth_d;
  logic [COLOR_W-1:0] best_color_q, best_color_d;

  // Strict less-than: on equal depth the earlier (lower index) sphere wins.
  always_comb begin
    best_depth_d = best_depth_q;
    best_color_d = best_color_q;
    if (clear) begin
      best_depth_d = '1;
      best_color_d = BG_COLOR;
    end else if (result && sphere_hit && (hit_depth < best_depth_q)) begin
      best_depth_d = hit_depth;
      best_color_d = hit_color;
    end
  end

  assign sel_color = best_color_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_depth_q <= '1;
      best_color_q <= BG_COLOR;
    end else begin
      best_depth_q <= best_depth_d;
      best_color_q <= best_color_d;
    end
  end

endmodule

// File: rtl/raytrace_pixel_scheduler.sv
// Frame sequencer upstream of the ray-trace core: walks the raster, launches the
// core per pixel, steps it through every sphere, keeps the nearest hit and hands
// the pixel to the framebuffer writer over a valid/ready port.
//   clk, rst                : clock, asynchronous active-high reset
//   frame_start / frame_busy: frame request (ignored while busy) / frame in flight
//   core_start              : launch pulse to the core
//   core_busy, res_valid    : core tracing / result present (counted only while busy)
//   sph_idx, next_sphere    : sphere under test / advance pulse
//   pixel_done              : all spheres tested for this pixel
//   sphere_hit, hit_depth, hit_color : per-sphere result
//   px_valid/px_ready, px_x, px_y, px_color, px_last : pixel output port
// All outputs are registered; none depends combinationally on px_ready.
module raytrace_pixel_scheduler
  import raytrace_pkg::*;
#(
  parameter int unsigned        H_RES       = 640,
  parameter int unsigned        V_RES       = 480,
  parameter int unsigned        NUM_SPHERES = 8,
  parameter int unsigned        COLOR_W     = PkgColorW,
  parameter int unsigned        DEPTH_W     = PkgDepthW,
  parameter logic [COLOR_W-1:0] BG_COLOR    = DefaultBgColor,
  localparam int unsigned       SphW        = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
  localparam int unsigned       XW          = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int unsigned       YW          = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output logic               frame_busy,
  output logic               core_start,
  input  logic               core_busy,
  output logic [SphW-1:0]    sph_idx,
  output logic               next_sphere,
  output logic               pixel_done,
  input  logic               res_valid,
  input  logic               sphere_hit,
  input  logic [DEPTH_W-1:0] hit_depth,
  input  logic [COLOR_W-1:0] hit_color,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [XW-1:0]      px_x,
  output logic [YW-1:0]      px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               px_last
);

  localparam logic [SphW-1:0] LastSph = SphW'(NUM_SPHERES - 1);
  localparam logic [XW-1:0]   LastX   = XW'(H_RES - 1);
  localparam logic [YW-1:0]   LastY   = YW'(V_RES - 1);

  sched_state_e       state_q;
  logic               result;
  logic [COLOR_W-1:0] sel_color;

  assign result = (state_q == StSphere) && res_valid && core_busy;

  raytrace_hit_select #(
    .COLOR_W  (COLOR_W),
    .DEPTH_W  (DEPTH_W),
    .BG_COLOR (BG_COLOR)
  ) u_hit_select (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == StLaunch),
    .result     (result),
    .sphere_hit (sphere_hit),
    .hit_depth  (hit_depth),
    .hit_color  (hit_color),
    .sel_color  (sel_color)
  );

  // px_x/px_y double as the raster counters; they only move on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      frame_busy  <= 1'b0;
      core_start  <= 1'b0;
      sph_idx     <= '0;
      next_sphere <= 1'b0;
      pixel_done  <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_color    <= '0;
      px_last     <= 1'b0;
    end else begin
      core_start  <= 1'b0;
      next_sphere <= 1'b0;
      pixel_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            px_x       <= '0;
            px_y       <= '0;
            sph_idx    <= '0;
            frame_busy <= 1'b1;
            core_start <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: begin
          sph_idx <= '0;
          state_q <= StSphere;
        end
        StSphere: begin
          if (result) begin
            if (sph_idx == LastSph) begin
              pixel_done <= 1'b1;
              px_valid   <= 1'b1;
              px_color   <= sel_color;
              px_last    <= (px_x == LastX) && (px_y == LastY);
              state_q    <= StWrite;
            end else begin
              sph_idx     <= sph_idx + 1'b1;
              next_sphere <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (px_ready) begin
            px_valid <= 1'b0;
            px_last  <= 1'b0;
            sph_idx  <= '0;
            if (px_last) begin
              px_x       <= '0;
              px_y       <= '0;
              frame_busy <= 1'b0;
              state_q    <= StIdle;
            end else begin
              core_start <= 1'b1;
              state_q    <= StLaunch;
              if (px_x == LastX) begin
                px_x <= '0;
                px_y <= px_y + 1'b1;
              end else begin
                px_x <= px_x + 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
